// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with per-frame input shadowing,
// leading-zero blanking, per-digit blink and decimal-point control.
module seg7_scan_driver #(
  parameter int unsigned SCAN_CNT_W  = 16,
  parameter int unsigned BLINK_CNT_W = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blink_mask,
  input  logic       blank_lz,
  output logic [3:0] DIGIT,
  output logic [6:0] DISPLAY,
  output logic       DP,
  output logic       frame_tick
);

  logic [SCAN_CNT_W-1:0]  scan_cnt;
  logic [BLINK_CNT_W-1:0] blink_cnt;
  logic                   blink_phase;
  logic [1:0]             idx;
  logic [3:0][3:0]        sh_bcd;
  logic [3:0]             sh_dp;
  logic [3:0]             sh_blink;

  logic                   wrap;
  logic                   capture;
  logic                   phase_nxt;
  logic [1:0]             idx_nxt;
  logic [3:0][3:0]        eff_bcd;
  logic [3:0]             eff_dp;
  logic [3:0]             eff_blink;
  logic [3:0]             lz_mask;
  logic [3:0]             digit_nxt;
  logic [6:0]             seg_nxt;
  logic                   dp_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'b100_0000;
      4'd1:    seg_decode = 7'b111_1001;
      4'd2:    seg_decode = 7'b010_0100;
      4'd3:    seg_decode = 7'b011_0000;
      4'd4:    seg_decode = 7'b001_1001;
      4'd5:    seg_decode = 7'b001_0010;
      4'd6:    seg_decode = 7'b000_0010;
      4'd7:    seg_decode = 7'b111_1000;
      4'd8:    seg_decode = 7'b000_0000;
      4'd9:    seg_decode = 7'b001_0000;
      4'd10:   seg_decode = 7'b011_1111;
      default: seg_decode = 7'b111_1111;
    endcase
  endfunction

  always_comb begin
    wrap      = &scan_cnt;
    capture   = wrap && (idx == 2'd3);
    phase_nxt = blink_phase ^ (&blink_cnt);
    idx_nxt   = idx + 2'd1;

    // On a capture edge digit 0 is decoded straight from the values being latched.
    eff_bcd   = capture ? {bcd3, bcd2, bcd1, bcd0} : sh_bcd;
    eff_dp    = capture ? dp_mask : sh_dp;
    eff_blink = capture ? blink_mask : sh_blink;

    lz_mask    = '0;
    lz_mask[3] = blank_lz && (eff_bcd[3] == 4'd0);
    lz_mask[2] = lz_mask[3] && (eff_bcd[2] == 4'd0);
    lz_mask[1] = lz_mask[2] && (eff_bcd[1] == 4'd0);

    digit_nxt = ~(4'b0001 << idx_nxt);
    seg_nxt   = lz_mask[idx_nxt] ? 7'h7F : seg_decode(eff_bcd[idx_nxt]);
    dp_nxt    = ~eff_dp[idx_nxt];
    if (phase_nxt && eff_blink[idx_nxt]) begin
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      idx         <= 2'd3;
      sh_bcd      <= {4{4'd11}};
      sh_dp       <= '0;
      sh_blink    <= '0;
      DIGIT       <= '1;
      DISPLAY     <= '1;
      DP          <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      scan_cnt    <= scan_cnt + 1'b1;
      blink_cnt   <= blink_cnt + 1'b1;
      blink_phase <= phase_nxt;
      frame_tick  <= capture;
      if (wrap) begin
        idx     <= idx_nxt;
        DIGIT   <= digit_nxt;
        DISPLAY <= seg_nxt;
        DP      <= dp_nxt;
      end
      if (capture) begin
        sh_bcd   <= {bcd3, bcd2, bcd1, bcd0};
        sh_dp    <= dp_mask;
        sh_blink <= blink_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: an edge-counting reference model queues the
// expected outputs for every clock, and a monitor compares them on the falling edge.
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic [3:0] dp_mask, blink_mask;
  logic       blank_lz;
  logic [3:0] DIGIT;
  logic [6:0] DISPLAY;
  logic       DP;
  logic       frame_tick;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct packed {
    logic [3:0] digit;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } out_t;

  out_t expq[$];

  seg7_scan_driver #(.SCAN_CNT_W(2), .BLINK_CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .bcd3       (bcd3),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .DIGIT      (DIGIT),
    .DISPLAY    (DISPLAY),
    .DP         (DP),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: with a 4-clock digit period and 16-clock blink half-period,
  // everything follows from the number of edges since reset release.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  int         k;
  logic [3:0] m_bcd [4];
  logic [3:0] m_dp, m_bl;
  out_t       held;

  always @(posedge clk) begin
    out_t r;
    int   d;
    bit   phase, blanked;
    if (!rst) begin
      k = 0;
      for (int i = 0; i < 4; i++) m_bcd[i] = 4'd11;
      m_dp = '0;
      m_bl = '0;
      held = '{digit: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
      expq.push_back(held);
    end else begin
      k++;
      r = held;
      r.tick = 1'b0;
      if (k % 4 == 0) begin
        d = (k / 4 + 3) % 4;
        if (d == 0) begin
          m_bcd[0] = bcd0; m_bcd[1] = bcd1; m_bcd[2] = bcd2; m_bcd[3] = bcd3;
          m_dp = dp_mask;
          m_bl = blink_mask;
          r.tick = 1'b1;
        end
        phase = ((k / 16) % 2) == 1;
        blanked = blank_lz && (d > 0);
        for (int j = d; j < 4; j++) if (m_bcd[j] != 4'd0) blanked = 1'b0;
        r.digit = 4'hF;
        r.digit[d] = 1'b0;
        r.seg = blanked ? 7'h7F : seg_tab[m_bcd[d]];
        r.dp = ~m_dp[d];
        if (phase && m_bl[d]) begin
          r.seg = 7'h7F;
          r.dp  = 1'b1;
        end
        held = r;
        held.tick = 1'b0;
      end
      expq.push_back(r);
    end
  end

  always @(negedge clk) begin
    out_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if ({DIGIT, DISPLAY, DP, frame_tick} === e)
        passes++;
      else
        $display("FAIL outputs t=%0t k=%0d: got DIGIT=%b DISPLAY=%b DP=%b tick=%b, exp DIGIT=%b DISPLAY=%b DP=%b tick=%b",
                 $time, k, DIGIT, DISPLAY, DP, frame_tick, e.digit, e.seg, e.dp, e.tick);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (DIGIT === 4'hF && DISPLAY === 7'h7F && DP === 1'b1 && frame_tick === 1'b0)
      passes++;
    else
      $display("FAIL async_reset: got DIGIT=%b DISPLAY=%b DP=%b tick=%b, exp 1111 1111111 1 0",
               DIGIT, DISPLAY, DP, frame_tick);
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    set_bcd(4'd1, 4'd2, 4'd3, 4'd5);
    dp_mask = '0;
    blink_mask = '0;
    blank_lz = 1'b0;
    step(2);
    rst = 1'b1;
    // first capture at edge 4 takes 1,2,3,5; then 1,2,3,4 for the next frame
    step(4);
    bcd0 = 4'd4;
    step(24);
    bcd1 = 4'd7;
    step(24);
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    blank_lz = 1'b1;
    step(32);
    set_bcd(4'd0, 4'd1, 4'd0, 4'd5);
    step(32);
    blink_mask = 4'b0001;
    dp_mask = 4'b0001;
    step(64);
    step(6);
    async_reset_check();
    step(24);
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(1, 7));
      set_bcd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) set_bcd(4'd0, 4'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 15)));
      dp_mask = 4'($urandom);
      blink_mask = 4'($urandom);
      blank_lz = 1'($urandom);
      if (n == 150) async_reset_check();
    end
    step(8);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0)
      passes++;
    else
      $display("FAIL queue_drain: got %0d pending, exp 0", expq.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
